read_ram_addr_gen: RTL and testbench
====================================

READ_RAM_ADDR_GEN -- requirements
Module: read_ram_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 8: width of ramAddress and dataLength.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 srst  input  1  reset, synchronous and active-high.
REQ-004 enable  input  1  one-cycle start pulse; the caller supplies an edge-detected pulse.
REQ-005 txBusy  input  1  UART transmitter busy level; a 1->0 transition means the current byte is done.
REQ-006 dataLength  input  ADDR_W  number of RAM bytes to read and send.
REQ-007 txTrig  output  1  one-cycle pulse requesting transmission of the byte at ramAddress.
REQ-008 ramAddress  output  ADDR_W  current RAM read address.
REQ-009 finishFlag  output  1  high once all bytes are sent; held until the next start.

Function
REQ-010 States SHALL be IDLE, TRIG, WAIT_DONE and FINISH, held in a registered state variable.
REQ-011 IDLE or FINISH with enable=1: at the next edge, latch dataLength into len_r, set ramAddress=0, clear finishFlag, and go to TRIG.
REQ-012 If the latched length is 0, the block SHALL go directly from start to FINISH with no txTrig pulse.
REQ-013 TRIG SHALL drive txTrig=1 for exactly one cycle, then go to WAIT_DONE.
REQ-014 WAIT_DONE SHALL wait for a falling edge of txBusy (txBusy=0 while the registered previous value is 1); txBusy held low or high without a 1->0 transition SHALL NOT advance the block.
REQ-015 Falling edge with ramAddress != len_r-1: at the next edge, increment ramAddress by 1 and go to TRIG.
REQ-016 Falling edge with ramAddress == len_r-1: at the next edge, hold ramAddress, set finishFlag=1 and go to FINISH.
REQ-017 FINISH SHALL hold finishFlag=1 and ramAddress until enable.
REQ-018 enable in TRIG or WAIT_DONE SHALL be ignored (no restart).
REQ-019 Changes to dataLength after start SHALL have no effect until the next start.
REQ-020 ramAddress SHALL never exceed len_r-1, and arithmetic SHALL be unsigned ADDR_W.
REQ-021 The number of txTrig pulses per run SHALL equal len_r.
REQ-022 txTrig SHALL be a registered-state (Moore) output with no combinational path from inputs.

Reset
REQ-023 srst=1 at a clock edge SHALL force state=IDLE, ramAddress=0, txTrig=0, finishFlag=0, len_r=0, and the edge-detector history=0, including mid-run.
REQ-024 Because the history resets to 0, a txBusy held high through reset SHALL NOT produce a false falling edge.

Structure
REQ-025 One sub-module, edge_detector, SHALL provide falling-edge detection of txBusy.
- Ports: clk, srst, signal, signal_posedge, signal_negedge, signal_dual_edge.
- The history bit is registered; the edge outputs are combinational from signal and the history bit.
REQ-026 edge_detector is also the block used upstream to turn a start level into the enable pulse.
REQ-027 The state encoding localparams and the ADDR_W default SHALL live in a shared package, read_ram_pkg.

Verification
REQ-028 The bench drives txBusy from a free-running 0..50 counter, busy=1 when counter<40.
REQ-029 dataLength=3, one enable pulse -> txTrig pulses with ramAddress=0, 1, 2 in turn; finishFlag=1 one cycle after the third txBusy falling edge; ramAddress stays at 2.
REQ-030 dataLength=0, enable -> finishFlag=1 within 2 cycles; no txTrig pulse; ramAddress=0.
REQ-031 dataLength=1, enable, then dataLength changed to 5 mid-run -> exactly one txTrig pulse, then finishFlag=1.
REQ-032 srst pulsed while ramAddress=1 in WAIT_DONE -> the next cycle shows state IDLE, ramAddress=0, finishFlag=0; no txTrig until a new enable.
REQ-033 Run of 3 finishes, then enable again with dataLength=2 -> finishFlag clears on the cycle after enable; addresses 0 and 1 are triggered; finishFlag set again.
REQ-034 enable re-pulsed during WAIT_DONE -> ignored; address sequence and trigger count are unchanged.

Source files
------------

// File: rtl/read_ram_pkg.sv
// Shared definitions for the RAM read-address generator: default address
// width and the controller state encoding.
package read_ram_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_TRIG      = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_FINISH    = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        TRIG      = ST_TRIG,
        WAIT_DONE = ST_WAIT_DONE,
        FINISH    = ST_FINISH
    } state_t;

endpackage

// File: rtl/edge_detector.sv
// Single-bit edge detector. The previous value of the input is registered;
// the edge outputs are combinational from the live input and that history.
// The same block turns a start level into a one-cycle enable pulse upstream.
module edge_detector (
    input  logic clk,
    input  logic srst,
    input  logic signal,
    output logic signal_posedge,
    output logic signal_negedge,
    output logic signal_dual_edge
);

    logic signal_d;

    // History register; cleared on reset so a level held high through reset
    // is never mistaken for a falling edge afterwards.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (srst) begin
            signal_d <= 1'b0;
        end else begin
            signal_d <= signal;
        end
    end

    assign signal_posedge   =  signal & ~signal_d;
    assign signal_negedge   = ~signal &  signal_d;
    assign signal_dual_edge =  signal ^  signal_d;

endmodule

// File: rtl/read_ram_addr_gen.sv
// Walks RAM addresses 0..len-1, requesting one UART transmission per byte and
// advancing only after the transmitter signals completion with a falling
// edge on txBusy. finishFlag stays high after the last byte until restarted.
module read_ram_addr_gen
    import read_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              enable,
    input  logic              txBusy,
    input  logic [ADDR_W-1:0] dataLength,
    output logic              txTrig,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              finishFlag
);

    state_t            state,       state_n;
    logic [ADDR_W-1:0] ram_address, ram_address_n;
    logic [ADDR_W-1:0] len_r,       len_n;
    logic              finish_flag, finish_flag_n;
    logic [ADDR_W-1:0] last_addr;
    logic              busy_fall;
    logic              busy_rise_unused;
    logic              busy_dual_unused;

    edge_detector u_busy_edge (
        .clk              (clk),
        .srst             (srst),
        .signal           (txBusy),
        .signal_posedge   (busy_rise_unused),
        .signal_negedge   (busy_fall),
        .signal_dual_edge (busy_dual_unused)
    );

    // Only meaningful in WAIT_DONE, where len_r is known to be non-zero.
    assign last_addr = len_r - ADDR_W'(1);

    // State, address, latched length and finish flag registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= IDLE;
            ram_address <= '0;
            len_r       <= '0;
            finish_flag <= 1'b0;
        end else begin
            state       <= state_n;
            ram_address <= ram_address_n;
            len_r       <= len_n;
            finish_flag <= finish_flag_n;
        end
    end

    // Next-state and next-value logic for the controller.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n       = state;
        ram_address_n = ram_address;
        len_n         = len_r;
        finish_flag_n = finish_flag;

        case (state)
            IDLE, FINISH: begin
                // FINISH keeps the flag asserted; a zero-length start lands
                // here with the flag cleared and raises it one cycle later.
                if (state == FINISH) begin
                    finish_flag_n = 1'b1;
                end
                if (enable) begin
                    len_n         = dataLength;
                    ram_address_n = '0;
                    finish_flag_n = 1'b0;
                    state_n       = (dataLength == '0) ? FINISH : TRIG;
                end
            end

            TRIG: begin
                state_n = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (busy_fall) begin
                    if (ram_address == last_addr) begin
                        finish_flag_n = 1'b1;
                        state_n       = FINISH;
                    end else begin
                        ram_address_n = ram_address + ADDR_W'(1);
                        state_n       = TRIG;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Moore outputs straight from registered state.
    assign txTrig     = (state == TRIG);
    assign ramAddress = ram_address;
    assign finishFlag = finish_flag;

endmodule

// File: tb/tb_read_ram_addr_gen.sv
// Randomized scoreboard bench for read_ram_addr_gen. Stimulus pushes the
// expected trigger addresses and finish event for each run; a monitor pops
// and compares whenever the DUT pulses txTrig or raises finishFlag.
module tb_read_ram_addr_gen;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          srst;
    logic          enable;
    logic          txBusy;
    logic [AW-1:0] dataLength;
    logic          txTrig;
    logic [AW-1:0] ramAddress;
    logic          finishFlag;

    typedef struct {
        bit is_fin;
        int addr;
        bit zero_len;
    } exp_t;

    exp_t sb[$];

    int n_checks      = 0;
    int n_pass        = 0;
    int cyc           = 0;
    int start_cyc     = 0;
    int last_fall_cyc = -100;
    int busy_cnt      = 0;

    read_ram_addr_gen #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .srst       (srst),
        .enable     (enable),
        .txBusy     (txBusy),
        .dataLength (dataLength),
        .txTrig     (txTrig),
        .ramAddress (ramAddress),
        .finishFlag (finishFlag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Free-running transmitter model: busy while counter < 40, period 51.
    initial begin
        txBusy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            busy_cnt = (busy_cnt == 50) ? 0 : busy_cnt + 1;
            if (txBusy && !(busy_cnt < 40)) last_fall_cyc = cyc;
            txBusy = (busy_cnt < 40);
        end
    end

    // Monitor: compares each DUT event against the head of the scoreboard.
    initial begin
        exp_t e;
        bit   prev_fin;
        prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (!srst) begin
                if (txTrig) begin
                    if (sb.size() == 0) begin
                        check("unexpected_trig", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("trig_kind", e.is_fin, 0);
                        check("trig_addr", ramAddress, e.addr);
                        if (e.addr == 0) check("trig_start_latency", cyc - start_cyc, 1);
                        else             check("trig_fall_latency", cyc - last_fall_cyc, 1);
                    end
                end
                if (finishFlag && !prev_fin) begin
                    if (sb.size() == 0) begin
                        check("unexpected_finish", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("fin_kind", e.is_fin, 1);
                        check("fin_addr", ramAddress, e.addr);
                        if (e.zero_len) check("zero_len_within_2", (cyc - start_cyc) <= 2, 1);
                        else            check("fin_fall_latency", cyc - last_fall_cyc, 1);
                    end
                end
            end
            prev_fin = finishFlag;
        end
    end

    // Start one run of length len and record what the specification expects.
    task automatic start_run(input int len);
        dataLength = AW'(len);
        @(posedge clk);
        #1;
        enable    = 1'b1;
        start_cyc = cyc;
        for (int i = 0; i < len; i++) sb.push_back('{is_fin: 1'b0, addr: i, zero_len: 1'b0});
        sb.push_back('{is_fin: 1'b1, addr: (len == 0) ? 0 : len - 1, zero_len: (len == 0)});
        @(posedge clk);
        #1;
        enable = 1'b0;
        if (len != 0) begin
            @(negedge clk);
            check("fin_cleared_after_start", finishFlag, 0);
        end
    endtask

    // Wait (bounded) for the scoreboard to drain, then check the held state.
    task automatic wait_done(input int len);
        int n = 0;
        int budget = 60 * (len + 2) + 20;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("run_timeout_pending", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold_finish", finishFlag, 1);
        check("hold_addr", ramAddress, (len == 0) ? 0 : len - 1);
        check("hold_no_trig", txTrig, 0);
    endtask

    // Pulse enable while the block is waiting on the transmitter.
    task automatic pulse_enable_in_wait();
        @(posedge clk);
        #1;
        if (!txTrig && !finishFlag) begin
            dataLength = AW'($urandom_range(0, 255));
            enable     = 1'b1;
            @(posedge clk);
            #1;
            enable = 1'b0;
        end else begin
            check("expected_wait_state", {txTrig, finishFlag}, 0);
        end
    endtask

    initial begin
        int  len;
        bit  found;

        srst       = 1'b1;
        enable     = 1'b0;
        dataLength = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_trig", txTrig, 0);
        check("reset_finish", finishFlag, 0);
        check("reset_addr", ramAddress, 0);
        @(posedge clk);
        #1;
        srst = 1'b0;
        repeat (5) @(posedge clk);

        // Basic three-byte run.
        start_run(3);
        wait_done(3);

        // Zero length: finish with no trigger.
        start_run(0);
        wait_done(0);

        // Length changed after start has no effect.
        start_run(1);
        repeat (4) @(posedge clk);
        #1;
        dataLength = 8'd5;
        wait_done(1);

        // Reset while waiting on address 1.
        start_run(3);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ramAddress == 8'd1 && !txTrig) found = 1'b1;
        end
        check("reached_addr1_wait", found, 1);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrun_reset_addr", ramAddress, 0);
        check("midrun_reset_finish", finishFlag, 0);
        check("midrun_reset_trig", txTrig, 0);
        repeat (120) @(posedge clk);

        // Back-to-back runs: 3 then 2.
        start_run(3);
        wait_done(3);
        start_run(2);
        wait_done(2);

        // Enable re-pulsed during WAIT_DONE is ignored.
        start_run(3);
        pulse_enable_in_wait();
        wait_done(3);

        // Randomized runs with mid-run disturbances.
        for (int r = 0; r < 10; r++) begin
            repeat ($urandom_range(1, 60)) @(posedge clk);
            len = $urandom_range(0, 5);
            start_run(len);
            if (len != 0) begin
                if ($urandom_range(0, 1) == 1) pulse_enable_in_wait();
                dataLength = AW'($urandom_range(0, 255));
            end
            wait_done(len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
